// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1-to-8 round-robin demux scheduler.
//   NCH   : number of output channels (fixed at 8)
//   SEL_W : width of the channel select index
//   CNT_W : width of the optional dispatch counter
//   state_t : scheduler states IDLE / ARB / SEND
package demux_sched_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  // One-hot channel vector for a select index.
  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    sel_onehot = NCH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker over an 8-bit mask.
//   mask  : candidate channels
//   start : index scanned first; scan continues start+1, ... modulo 8
//   idx   : first set channel found in scan order (0 when none)
//   found : at least one mask bit is set
module rr_pick8
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Walk the scan order and latch the first hit; the 3-bit add wraps 7->0.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && mask[start + SEL_W'(i)]) begin
        idx   = start + SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux1x8_rr_scheduler.sv
// Round-robin scheduler for a 1-to-8 demux datapath. Accepts one item on a
// valid/ready input, picks an enabled channel starting at the rr pointer,
// and holds the item on the broadcast bus until that channel accepts it.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_data/in_ready : upstream handshake
//   ch_en        : per-channel enable mask, sampled while arbitrating
//   out_ready    : per-channel accept
//   out_valid    : one-hot valid to the selected channel, or zero
//   out_data     : held item, broadcast to all channels
//   sel          : demux select of the current or last-served channel
//   busy         : scheduler is not idle
// Optional (DEMUX1X8_RR_SCHEDULER_CNT_EN defined):
//   cnt_clr      : synchronous counter clear, wins over a same-cycle count
//   dispatch_cnt : completed-transfer count, wraps at 16 bits
module demux1x8_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 1
)
(
  input  logic              clk,
  input  logic              rst,
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  dispatch_cnt,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH-1:0]    out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [DATA_W-1:0]  hold;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               xfer_done;

  rr_pick8 u_pick (
    .mask  (ch_en),
    .start (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign xfer_done = (state == SEND) && out_ready[sel];

  // Scheduler FSM; out_valid is loaded with the SEND one-hot on entry so it
  // is a plain register that cannot retract until the transfer completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      hold      <= '0;
      out_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            state <= ARB;
          end
        end
        ARB: begin
          if (pick_found) begin
            sel       <= pick_idx;
            out_valid <= sel_onehot(pick_idx);
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer_done) begin
            ptr       <= sel + SEL_W'(1);
            out_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is held low through reset so nothing is taken while flushing.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign out_data = hold;

`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
  // Completed-transfer counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      dispatch_cnt <= '0;
    end else if (xfer_done) begin
      dispatch_cnt <= dispatch_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux1x8_rr_scheduler.sv
module tb_demux1x8_rr_scheduler;
  import demux_sched_pkg::*;

  localparam int unsigned DW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    ch_en;
  logic [7:0]    out_ready;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    sel;
  logic          busy;
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
  logic          cnt_clr;
  logic [15:0]   dispatch_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0=waiting for item, 1=choosing channel, 2=offering.
  int            m_phase;
  int            m_ptr;
  int            m_sel;
  logic [DW-1:0] m_hold;
  int            m_cnt;
  int            served[$];

  demux1x8_rr_scheduler #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
    .cnt_clr      (cnt_clr),
    .dispatch_cnt (dispatch_cnt),
`endif
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ch_en        (ch_en),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .sel          (sel),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step();
    bit done;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_sel = 0; m_hold = '0; m_cnt = 0;
    end else begin
      done = (m_phase == 2) && out_ready[m_sel];
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (done) m_cnt = (m_cnt + 1) % 65536;
`endif
      case (m_phase)
        0: if (in_valid) begin m_hold = in_data; m_phase = 1; end
        1: begin
          for (int k = 0; k < 8; k++) begin
            if (ch_en[(m_ptr + k) % 8]) begin
              m_sel = (m_ptr + k) % 8;
              m_phase = 2;
              break;
            end
          end
        end
        default: if (done) begin
          served.push_back(m_sel);
          m_ptr = (m_sel + 1) % 8;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_ov;
    exp_ov = (m_phase == 2) ? 8'(1 << m_sel) : 8'h00;
    chk("in_ready",  32'(in_ready),  32'((m_phase == 0) && !rst));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("out_data",  32'(out_data),  32'(m_hold));
    chk("sel",       32'(sel),       32'(m_sel));
    chk("busy",      32'(busy),      32'(m_phase != 0));
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
    chk("dispatch_cnt", 32'(dispatch_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_phase(input int target);
    int b = 0;
    while (m_phase != target && b < 50) begin cycle(); b++; end
    chk("wait_phase_timeout", 32'(b < 50), 32'd1);
  endtask

  // Present an item and hold in_valid until the edge that accepts it.
  task automatic push_item(input logic [DW-1:0] d);
    wait_phase(0);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic check_served(input string nm, input int exp[$]);
    chk({nm, "_len"}, 32'(served.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < served.size(); i++)
      chk(nm, 32'(served[i]), 32'(exp[i]));
  endtask

  initial begin
    int exp_q[$];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ch_en = 8'hFF; out_ready = 8'hFF;
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
    cnt_clr = 1'b0;
`endif
    m_phase = 0; m_ptr = 0; m_sel = 0; m_hold = '0; m_cnt = 0;

    // Reset then a single item.
    cycle(); cycle();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_out_valid", 32'(out_valid), 32'h0);
    cycle();
    chk("c2_out_valid", 32'(out_valid), 32'h01);
    chk("c2_sel", 32'(sel), 32'd0);
    chk("c2_out_data", 32'(out_data), 32'd1);
    cycle();
    chk("c3_in_ready", 32'(in_ready), 32'd1);

    // Round-robin wrap from a fresh pointer.
    rst = 1'b1; cycle(); rst = 1'b0;
    served.delete();
    for (int i = 0; i < 10; i++) begin
      push_item(DW'(i));
      wait_phase(0);
    end
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    check_served("rr_wrap", exp_q);

    // Sparse mask.
    served.delete();
    ch_en = 8'b1010_0100;
    for (int i = 0; i < 4; i++) begin
      push_item(DW'(i));
      wait_phase(0);
    end
    exp_q = '{2, 5, 7, 2};
    check_served("sparse", exp_q);

    // Backpressure: pointer is at 3, so channel 3 is offered and must not retract.
    ch_en = 8'hFF; out_ready = 8'h00;
    push_item(1'b1);
    wait_phase(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) ch_en = 8'hF7;
      if (i >= 3) out_ready = 8'hF7;
      cycle();
      chk("bp_sel", 32'(sel), 32'd3);
      chk("bp_out_valid", 32'(out_valid), 32'h08);
      chk("bp_out_data", 32'(out_data), 32'd1);
    end
    out_ready = 8'h08;
    cycle();
    chk("bp_done_busy", 32'(busy), 32'd0);

    // Empty mask holds in arbitration until reset.
    ch_en = 8'h00; out_ready = 8'hFF;
    push_item(1'b0);
    for (int i = 0; i < 4; i++) cycle();
    chk("empty_busy", 32'(busy), 32'd1);
    chk("empty_out_valid", 32'(out_valid), 32'h0);
    chk("empty_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; cycle(); rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    ch_en = 8'hFF;
    push_item(1'b1);
    wait_phase(2);
    chk("post_rst_sel", 32'(sel), 32'd0);
    wait_phase(0);

`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
    // Counter: three transfers, then a clear colliding with the fourth.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_item(1'b1);
      wait_phase(0);
    end
    chk("cnt_three", 32'(dispatch_cnt), 32'd3);
    out_ready = 8'h00;
    push_item(1'b0);
    wait_phase(2);
    out_ready = 8'hFF; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", 32'(dispatch_cnt), 32'd0);
    chk("cnt_clr_xfer", 32'(busy), 32'd0);
`endif

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      ch_en     = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
`ifdef DEMUX1X8_RR_SCHEDULER_CNT_EN
      cnt_clr   = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
